// File: rtl/seg7_pkg.sv
// Shared constants for the 2-digit seven-segment scan driver: bus widths and
// segment patterns in {g,f,e,d,c,b,a} order, active-high.
package seg7_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; codes 10..15 show 'E'.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [SEG_W-1:0]   o_seg
);

    always_comb begin
        o_seg = SEG_E;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Latches an MSD/LSD digit pair and time-multiplexes it onto a 2-digit
// common-cathode display with per-slot dead time and leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int DEAD     = 1
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] msd,
    input  logic [DIGIT_W-1:0] lsd,
    input  logic               blank_lz,
    output logic [1:0]         an,
    output logic [SEG_W-1:0]   seg,
    output logic               frame_tick
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [DIGIT_W-1:0] r_msd;
    logic [DIGIT_W-1:0] r_lsd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sel;
    logic [1:0]         r_an;
    logic [SEG_W-1:0]   r_seg;
    logic               r_frame_tick;

    logic               w_wrap;
    logic               w_dead;
    logic               w_blank;
    logic [DIGIT_W-1:0] w_digit;
    logic [SEG_W-1:0]   w_seg;

    assign w_wrap  = (r_cnt == CNT_LAST);
    assign w_dead  = (int'({1'b0, r_cnt}) < DEAD);
    assign w_digit = r_sel ? r_lsd : r_msd;
    // Blanking only suppresses segments; the MSD anode still follows the scan.
    assign w_blank = !r_sel && blank_lz && (r_msd == '0);

    bcd_to_seg7 u_dec (
        .i_digit (w_digit),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_msd <= '0;
            r_lsd <= '0;
        end else if (ld) begin
            r_msd <= msd;
            r_lsd <= lsd;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt <= '0;
            r_sel <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_sel <= !r_sel;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Outputs are computed from the pre-edge slot state, so they lag cnt/sel by one cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_an         <= 2'b00;
            r_seg        <= SEG_BLANK;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_dead ? 2'b00 : (r_sel ? 2'b01 : 2'b10);
            r_seg        <= w_blank ? SEG_BLANK : w_seg;
            r_frame_tick <= r_sel && w_wrap;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_tick = r_frame_tick;

endmodule
